// File: rtl/bram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bram_port_arbiter_pkg
//  Description : Shared constants and types for the two-requester BRAM
//                port arbiter and its read-return tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
package bram_port_arbiter_pkg;

    localparam int unsigned c_num_req = 2;

    typedef logic [$clog2(c_num_req)-1:0] req_id_t;

    // One in-flight read: occupied flag plus the requester it returns to.
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_entry_t;

endpackage
`default_nettype wire

// File: rtl/bram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : bram_port_arbiter_if
//  Description : Requester-side bus of the BRAM port arbiter: request
//                handshake, write data and shared read-return channel.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bram_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    import bram_port_arbiter_pkg::*;

    logic [c_num_req-1:0]            req_valid;
    logic [c_num_req-1:0]            req_ready;
    logic [c_num_req-1:0]            req_we;
    logic [c_num_req*ADDR_WIDTH-1:0] req_addr;
    logic [c_num_req*DATA_WIDTH-1:0] req_din;
    logic [c_num_req-1:0]            rd_valid;
    logic [DATA_WIDTH-1:0]           rd_data;

    modport master (
        output req_valid, req_we, req_addr, req_din,
        input  req_ready, rd_valid, rd_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_din,
        output req_ready, rd_valid, rd_data
    );

endinterface
`default_nettype wire

// File: rtl/bram_rd_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : bram_rd_tracker
//  Description : RD_LAT-deep shift register of {valid, id} following each
//                issued read until its data leaves the BRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_rd_tracker
    import bram_port_arbiter_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  wire        clk,
    input  wire        rst,
    input  wire        issue_valid_i,
    input  req_id_t    issue_id_i,
    output rd_entry_t  head_o,
    output logic       regce_o
);

    rd_entry_t [RD_LAT-1:0] pipe_q;
    rd_entry_t [RD_LAT-1:0] pipe_d;

    always_comb begin
        pipe_d          = pipe_q;
        pipe_d[0].valid = issue_valid_i;
        pipe_d[0].id    = issue_id_i;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign head_o = pipe_q[RD_LAT-1];

    // With an output register the BRAM needs its clock enable one cycle
    // before data is due, i.e. while the read occupies the first stage.
    generate
        if (RD_LAT == 2) begin : g_regce
            assign regce_o = pipe_q[0].valid;
        end else begin : g_no_regce
            assign regce_o = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bram_port_arbiter
//  Description : Two-requester arbiter onto a single BRAM port, one access
//                per cycle, with in-order read-return steering.
//                Define BRAM_ARB_FIXED_PRIO_EN for fixed priority to
//                requester 0; default build is round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LAT     = 2
) (
    input  wire                     clk,
    input  wire                     rst,
    bram_port_arbiter_if.slave      req_if,
    output logic                    ram_en,
    output logic                    ram_we,
    output logic                    ram_regce,
    output logic                    ram_rst,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_din,
    input  wire  [DATA_WIDTH-1:0]   ram_dout
);

    logic      w_grant;
    req_id_t   w_idx;
    logic      w_we;
    logic      w_regce;
    rd_entry_t w_head;
    logic      w_rd_hit;

`ifndef BRAM_ARB_FIXED_PRIO_EN
    req_id_t   last_grant_q;
    req_id_t   last_grant_d;
`endif

    always_comb begin
        w_grant = (|req_if.req_valid) && !rst;
`ifdef BRAM_ARB_FIXED_PRIO_EN
        w_idx = ~req_if.req_valid[0];
`else
        // Under contention the requester served least recently wins.
        if (&req_if.req_valid) begin
            w_idx = ~last_grant_q;
        end else begin
            w_idx = ~req_if.req_valid[0];
        end
        last_grant_d = w_grant ? w_idx : last_grant_q;
`endif
    end

`ifndef BRAM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    always_comb begin
        w_we              = w_grant && (w_idx ? req_if.req_we[1] : req_if.req_we[0]);
        req_if.req_ready  = w_grant ? (w_idx ? 2'b10 : 2'b01) : 2'b00;
        ram_en            = w_grant;
        ram_we            = w_we;
        ram_addr          = '0;
        ram_din           = '0;
        if (w_grant) begin
            ram_addr = w_idx ? req_if.req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                             : req_if.req_addr[0 +: ADDR_WIDTH];
            ram_din  = w_idx ? req_if.req_din[DATA_WIDTH +: DATA_WIDTH]
                             : req_if.req_din[0 +: DATA_WIDTH];
        end
    end

    bram_rd_tracker #(
        .RD_LAT (RD_LAT)
    ) u_rd_tracker (
        .clk           (clk),
        .rst           (rst),
        .issue_valid_i (w_grant && !w_we),
        .issue_id_i    (w_idx),
        .head_o        (w_head),
        .regce_o       (w_regce)
    );

    // Reset masks the return path so nothing leaks out during rst.
    always_comb begin
        w_rd_hit         = w_head.valid && !rst;
        req_if.rd_valid  = w_rd_hit ? (w_head.id ? 2'b10 : 2'b01) : 2'b00;
        req_if.rd_data   = w_rd_hit ? ram_dout : '0;
        ram_regce        = w_regce && !rst;
        ram_rst          = rst;
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_port_arbiter
//  Description : Self-checking bench driving an RD_LAT=2 and an RD_LAT=1
//                arbiter with identical stimulus against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_init;
    logic [1:0]  t_valid, t_we;
    logic [9:0]  t_a0, t_a1;
    logic [31:0] t_d0, t_d1;

    always #5 clk = ~clk;

    bram_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) if2 ();
    bram_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) if1 ();

    assign if2.req_valid = t_valid;  assign if1.req_valid = t_valid;
    assign if2.req_we    = t_we;     assign if1.req_we    = t_we;
    assign if2.req_addr  = {t_a1, t_a0};  assign if1.req_addr = {t_a1, t_a0};
    assign if2.req_din   = {t_d1, t_d0};  assign if1.req_din  = {t_d1, t_d0};

    logic        r2_en, r2_we, r2_regce, r2_rst, r1_en, r1_we, r1_regce, r1_rst;
    logic [9:0]  r2_addr, r1_addr;
    logic [31:0] r2_din, r1_din, r2_dout, r1_dout, r2_lat;

    bram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .req_if(if2.slave),
        .ram_en(r2_en), .ram_we(r2_we), .ram_regce(r2_regce), .ram_rst(r2_rst),
        .ram_addr(r2_addr), .ram_din(r2_din), .ram_dout(r2_dout));

    bram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .req_if(if1.slave),
        .ram_en(r1_en), .ram_we(r1_we), .ram_regce(r1_regce), .ram_rst(r1_rst),
        .ram_addr(r1_addr), .ram_din(r1_din), .ram_dout(r1_dout));

    function automatic logic [31:0] init_val(input int i);
        return (i == 5) ? 32'h0000A5A5 : (32'hC0DE0000 | 32'(i));
    endfunction

    // Behavioural BRAMs: one with output register, one without.
    logic [31:0] mem2 [1024];
    logic [31:0] mem1 [1024];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem2[i] <= init_val(i);
        end else if (r2_en) begin
            if (r2_we) mem2[r2_addr] <= r2_din;
            else       r2_lat        <= mem2[r2_addr];
        end
        if (r2_rst)        r2_dout <= '0;
        else if (r2_regce) r2_dout <= r2_lat;
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem1[i] <= init_val(i);
        end else if (r1_en) begin
            if (r1_we) mem1[r1_addr] <= r1_din;
            else       r1_dout       <= mem1[r1_addr];
        end
        if (r1_rst) r1_dout <= '0;
    end

    // ---------------- reference model ----------------
    typedef struct { int issue; bit id; logic [31:0] data; } pend_t;
    pend_t       pend [$];
    logic [31:0] refmem [1024];
    int          cyc = 0;
    int          last_g = 1;
    bit          m_gv;
    int          m_g;
    int          checks = 0;
    int          errors = 0;

    logic [1:0]  s2_rdv, s1_rdv, s2_ready, s1_ready;
    logic [31:0] s2_rdd, s1_rdd;
    logic        s2_en, s1_en, s2_we, s1_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic find(input int target, output bit hit, output bit id, output logic [31:0] d);
        hit = 0; id = 0; d = '0;
        foreach (pend[i]) if (pend[i].issue == target) begin
            hit = 1; id = pend[i].id; d = pend[i].data;
        end
    endtask

    task automatic model_check();
        logic [1:0]  e_ready;
        logic [31:0] e_addr, e_din;
        logic        e_we;
        bit          hit, id;
        logic [31:0] d;
        m_gv = !rst && (t_valid != 2'b00);
        m_g  = 0;
`ifdef BRAM_ARB_FIXED_PRIO_EN
        m_g = t_valid[0] ? 0 : 1;
`else
        if (t_valid == 2'b11) m_g = 1 - last_g;
        else                  m_g = t_valid[0] ? 0 : 1;
`endif
        e_ready = m_gv ? 2'(1 << m_g) : 2'b00;
        e_we    = m_gv && t_we[m_g];
        e_addr  = m_gv ? 32'(m_g ? t_a1 : t_a0) : 32'd0;
        e_din   = m_gv ? (m_g ? t_d1 : t_d0) : 32'd0;
        chk("ready2", 32'(if2.req_ready), 32'(e_ready));
        chk("ready1", 32'(if1.req_ready), 32'(e_ready));
        chk("en2", 32'(r2_en), 32'(m_gv));       chk("en1", 32'(r1_en), 32'(m_gv));
        chk("we2", 32'(r2_we), 32'(e_we));       chk("we1", 32'(r1_we), 32'(e_we));
        chk("addr2", 32'(r2_addr), e_addr);      chk("addr1", 32'(r1_addr), e_addr);
        chk("din2", r2_din, e_din);              chk("din1", r1_din, e_din);
        chk("ramrst2", 32'(r2_rst), 32'(rst));   chk("ramrst1", 32'(r1_rst), 32'(rst));
        find(cyc - 2, hit, id, d);
        hit = hit && !rst;
        chk("rdvalid2", 32'(if2.rd_valid), hit ? 32'(1 << id) : 32'd0);
        if (hit || rst) chk("rddata2", if2.rd_data, hit ? d : 32'd0);
        find(cyc - 1, hit, id, d);
        hit = hit && !rst;
        chk("regce2", 32'(r2_regce), 32'(hit));
        chk("regce1", 32'(r1_regce), 32'd0);
        chk("rdvalid1", 32'(if1.rd_valid), hit ? 32'(1 << id) : 32'd0);
        if (hit || rst) chk("rddata1", if1.rd_data, hit ? d : 32'd0);
    endtask

    task automatic model_update();
        pend_t e;
        if (rst) begin
            pend.delete();
            last_g = 1;
        end else if (m_gv) begin
            if (t_we[m_g]) begin
                refmem[m_g ? t_a1 : t_a0] = m_g ? t_d1 : t_d0;
            end else begin
                e.issue = cyc; e.id = 1'(m_g); e.data = refmem[m_g ? t_a1 : t_a0];
                pend.push_back(e);
            end
            last_g = m_g;
        end
        cyc++;
        while (pend.size() > 0 && pend[0].issue < cyc - 2) void'(pend.pop_front());
    endtask

    task automatic cycle();
        @(negedge clk);
        model_check();
        s2_rdv = if2.rd_valid; s1_rdv = if1.rd_valid;
        s2_rdd = if2.rd_data;  s1_rdd = if1.rd_data;
        s2_ready = if2.req_ready; s1_ready = if1.req_ready;
        s2_en = r2_en; s1_en = r1_en; s2_we = r2_we; s1_we = r1_we;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] w,
                         input logic [9:0] a0, input logic [9:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        t_valid = v; t_we = w; t_a0 = a0; t_a1 = a1; t_d0 = d0; t_d1 = d1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [1:0]  valid, we;
        logic [9:0]  a0, a1;
        logic [31:0] d1;
        logic [1:0]  ready;
        logic        en, wen;
        logic [1:0]  rdv2;
        logic [31:0] rdd2;
    } vec_t;
    vec_t tbl [10];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        logic [1:0] seen;
        for (int i = 0; i < 1024; i++) refmem[i] = init_val(i);

        tbl[0] = '{2'b00, 2'b00, 10'd5, 10'd6, 32'h0,    2'b00, 1'b0, 1'b0, 2'b00, 32'h0};
        tbl[1] = '{2'b11, 2'b00, 10'd5, 10'd6, 32'h0,    2'b01, 1'b1, 1'b0, 2'b00, 32'h0};
`ifdef BRAM_ARB_FIXED_PRIO_EN
        tbl[2] = '{2'b11, 2'b00, 10'd5, 10'd6, 32'h0,    2'b01, 1'b1, 1'b0, 2'b00, 32'h0};
        tbl[3] = '{2'b11, 2'b00, 10'd5, 10'd6, 32'h0,    2'b01, 1'b1, 1'b0, 2'b01, 32'h0000A5A5};
        tbl[4] = '{2'b11, 2'b00, 10'd5, 10'd6, 32'h0,    2'b01, 1'b1, 1'b0, 2'b01, 32'h0000A5A5};
        tbl[5] = '{2'b10, 2'b10, 10'd0, 10'd7, 32'h1234, 2'b10, 1'b1, 1'b1, 2'b01, 32'h0000A5A5};
        tbl[6] = '{2'b01, 2'b00, 10'd7, 10'd0, 32'h0,    2'b01, 1'b1, 1'b0, 2'b01, 32'h0000A5A5};
`else
        tbl[2] = '{2'b11, 2'b00, 10'd5, 10'd6, 32'h0,    2'b10, 1'b1, 1'b0, 2'b00, 32'h0};
        tbl[3] = '{2'b11, 2'b00, 10'd5, 10'd6, 32'h0,    2'b01, 1'b1, 1'b0, 2'b01, 32'h0000A5A5};
        tbl[4] = '{2'b11, 2'b00, 10'd5, 10'd6, 32'h0,    2'b10, 1'b1, 1'b0, 2'b10, 32'hC0DE0006};
        tbl[5] = '{2'b10, 2'b10, 10'd0, 10'd7, 32'h1234, 2'b10, 1'b1, 1'b1, 2'b01, 32'h0000A5A5};
        tbl[6] = '{2'b01, 2'b00, 10'd7, 10'd0, 32'h0,    2'b01, 1'b1, 1'b0, 2'b10, 32'hC0DE0006};
`endif
        tbl[7] = '{2'b00, 2'b00, 10'd0, 10'd0, 32'h0,    2'b00, 1'b0, 1'b0, 2'b00, 32'h0};
        tbl[8] = '{2'b00, 2'b00, 10'd0, 10'd0, 32'h0,    2'b00, 1'b0, 1'b0, 2'b01, 32'h00001234};
        tbl[9] = '{2'b00, 2'b00, 10'd0, 10'd0, 32'h0,    2'b00, 1'b0, 1'b0, 2'b00, 32'h0};

        // Reset with both requesters asserting: nothing may be granted.
        rst = 1'b1; mem_init = 1'b1;
        drive(2'b11, 2'b00, 10'd1, 10'd2, 32'h0, 32'h0);
        cycle();
        mem_init = 1'b0;
        cycle(); cycle();
        chk("rst_ready", 32'(s2_ready), 32'd0);
        chk("rst_en", 32'(s2_en), 32'd0);
        chk("rst_rdvalid", 32'(s2_rdv), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].valid, tbl[i].we, tbl[i].a0, tbl[i].a1, 32'h0, tbl[i].d1);
            cycle();
            chk($sformatf("tbl%0d_ready", i), 32'(s2_ready), 32'(tbl[i].ready));
            chk($sformatf("tbl%0d_en", i), 32'(s2_en), 32'(tbl[i].en));
            chk($sformatf("tbl%0d_we", i), 32'(s2_we), 32'(tbl[i].wen));
            chk($sformatf("tbl%0d_rdv", i), 32'(s2_rdv), 32'(tbl[i].rdv2));
            if (tbl[i].rdv2 != 2'b00) chk($sformatf("tbl%0d_rdd", i), s2_rdd, tbl[i].rdd2);
        end

        // Lone read of addr 5: RD_LAT=2 returns two cycles after grant.
        drive(2'b01, 2'b00, 10'd5, 10'd0, 32'h0, 32'h0);
        cycle();
        drive(2'b00, 2'b00, 10'd0, 10'd0, 32'h0, 32'h0);
        cycle();
        chk("lone_rdv2_t1", 32'(s2_rdv), 32'd0);
        chk("lone_rdv1_t1", 32'(s1_rdv), 32'd1);
        chk("lone_rdd1_t1", s1_rdd, 32'h0000A5A5);
        cycle();
        chk("lone_rdv2_t2", 32'(s2_rdv), 32'd1);
        chk("lone_rdd2_t2", s2_rdd, 32'h0000A5A5);
        cycle();
        chk("lone_rdv2_t3", 32'(s2_rdv), 32'd0);

        // Alternating single-requester reads, eight back to back.
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive((i % 2) ? 2'b10 : 2'b01, 2'b00, 10'(8 + i), 10'(8 + i), 32'h0, 32'h0);
            else       drive(2'b00, 2'b00, 10'd0, 10'd0, 32'h0, 32'h0);
            cycle();
            if (s1_rdv != 2'b00) pulses++;
            if (i >= 1 && i <= 8) begin
                chk($sformatf("alt%0d_rdv1", i), 32'(s1_rdv), ((i - 1) % 2) ? 32'd2 : 32'd1);
                chk($sformatf("alt%0d_rdd1", i), s1_rdd, init_val(8 + i - 1));
            end else begin
                chk($sformatf("alt%0d_rdv1", i), 32'(s1_rdv), 32'd0);
            end
        end
        chk("alt_pulses", 32'(pulses), 32'd8);

        // Reset pulsed right after a read grant discards that read.
        drive(2'b01, 2'b00, 10'd5, 10'd0, 32'h0, 32'h0);
        cycle();
        rst = 1'b1;
        drive(2'b11, 2'b00, 10'd5, 10'd5, 32'h0, 32'h0);
        cycle();
        chk("rstpulse_ready2", 32'(s2_ready), 32'd0);
        chk("rstpulse_ready1", 32'(s1_ready), 32'd0);
        chk("rstpulse_en2", 32'(s2_en), 32'd0);
        chk("rstpulse_en1", 32'(s1_en), 32'd0);
        rst = 1'b0;
        drive(2'b00, 2'b00, 10'd0, 10'd0, 32'h0, 32'h0);
        seen = 2'b00;
        for (int i = 0; i < 4; i++) begin
            cycle();
            seen = seen | s2_rdv | s1_rdv;
        end
        chk("rstpulse_no_rdv", 32'(seen), 32'd0);

        // Idle inputs.
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("idle_en", 32'({s2_en, s1_en}), 32'd0);
            chk("idle_we", 32'({s2_we, s1_we}), 32'd0);
            chk("idle_rdv", 32'({s2_rdv, s1_rdv}), 32'd0);
        end

        // Random traffic with occasional reset, checked by the model.
        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  10'($urandom_range(0, 15)), 10'($urandom_range(0, 15)),
                  $urandom, $urandom);
            cycle();
        end
        rst = 1'b0;
        drive(2'b00, 2'b00, 10'd0, 10'd0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
